firebird7_in_gate1_scanmux_sel_ctrl: RTL and testbench

IJTAG-style select controller for a bank of NUM_MUX scan muxes. Each mux is a 2:1 path mux with select and enable split.
- Exposes a NUM_MUX-bit capture/shift/update data register on the IJTAG port and drives the registered mux_select vector.
- Sequences CSU phases with an FSM and checks shift-length integrity before committing a new select.
- Sits between the network's IJTAG control signals and the scanmux instances of the gate1 segment.

---
 rtl/firebird7_in_gate1_scanmux_sel_ctrl.sv | 98 +++++++++
 tb/tb_firebird7_in_gate1_scanmux_sel_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_scanmux_sel_ctrl.sv
// IJTAG capture/shift/update select controller for a bank of NUM_MUX scan muxes.
// A new select is committed only after a capture followed by exactly NUM_MUX shifts.
module firebird7_in_gate1_scanmux_sel_ctrl #(
    parameter int unsigned NUM_MUX   = 4,
    parameter logic [31:0] RESET_SEL = 32'd0
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               ijtag_sel,
    input  logic               ijtag_ce,
    input  logic               ijtag_se,
    input  logic               ijtag_ue,
    input  logic               ijtag_si,
    output logic               ijtag_so,
    output logic [NUM_MUX-1:0] mux_select,
    output logic [7:0]         update_count,
    output logic               protocol_err
);

    localparam int unsigned         CW       = $clog2(NUM_MUX + 2);
    localparam logic [NUM_MUX-1:0] RST_VAL  = RESET_SEL[NUM_MUX-1:0];
    localparam logic [CW-1:0]       CNT_FULL = CW'(NUM_MUX);
    localparam logic [CW-1:0]       CNT_SAT  = CW'(NUM_MUX + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, UPDATE} state_t;

    state_t             state, state_nxt;
    logic [NUM_MUX-1:0] sr, sr_nxt;
    logic [NUM_MUX-1:0] mux_select_nxt;
    logic [CW-1:0]      shift_cnt, shift_cnt_nxt;
    logic [7:0]         update_count_nxt;
    logic               protocol_err_nxt;
    logic               multi_en;

    assign multi_en = (ijtag_ce & ijtag_se) | (ijtag_ce & ijtag_ue) | (ijtag_se & ijtag_ue);
    assign ijtag_so = sr[0];

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state        <= IDLE;
            sr           <= RST_VAL;
            mux_select   <= RST_VAL;
            shift_cnt    <= '0;
            update_count <= '0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            mux_select   <= mux_select_nxt;
            shift_cnt    <= shift_cnt_nxt;
            update_count <= update_count_nxt;
            protocol_err <= protocol_err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sr_nxt           = sr;
        mux_select_nxt   = mux_select;
        shift_cnt_nxt    = shift_cnt;
        update_count_nxt = update_count;
        protocol_err_nxt = protocol_err;

        if (ijtag_sel) begin
            if (multi_en) begin
                protocol_err_nxt = 1'b1;
                state_nxt        = IDLE;
            end else if (ijtag_ce) begin
                sr_nxt        = mux_select;
                shift_cnt_nxt = '0;
                state_nxt     = CAPTURE;
            end else if (ijtag_se) begin
                // Bits always move; only a shift that follows a capture is counted.
                sr_nxt          = sr >> 1;
                sr_nxt[NUM_MUX-1] = ijtag_si;
                if (state == CAPTURE || state == SHIFT) begin
                    state_nxt = SHIFT;
                    if (shift_cnt != CNT_SAT) begin
                        shift_cnt_nxt = shift_cnt + 1'b1;
                    end
                end
            end else if (ijtag_ue) begin
                state_nxt = UPDATE;
                if (state == SHIFT && shift_cnt == CNT_FULL) begin
                    mux_select_nxt = sr;
                    if (update_count != 8'hFF) begin
                        update_count_nxt = update_count + 8'd1;
                    end
                end else begin
                    protocol_err_nxt = 1'b1;
                end
            end else if (state == UPDATE) begin
                state_nxt = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_scanmux_sel_ctrl.sv
// Directed scoreboard bench for the scan-mux select controller (NUM_MUX=4).
module tb_firebird7_in_gate1_scanmux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst, sel, ce, se, ue, si;
    logic       so;
    logic [3:0] ms;
    logic [7:0] cnt;
    logic       err;

    int vectors   = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [3:0] ms;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    exp_t sbq[$];

    firebird7_in_gate1_scanmux_sel_ctrl #(.NUM_MUX(4), .RESET_SEL(32'd0)) dut (
        .ijtag_tck    (clk),
        .ijtag_reset  (rst),
        .ijtag_sel    (sel),
        .ijtag_ce     (ce),
        .ijtag_se     (se),
        .ijtag_ue     (ue),
        .ijtag_si     (si),
        .ijtag_so     (so),
        .mux_select   (ms),
        .update_count (cnt),
        .protocol_err (err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
    task automatic cyc(input logic r, input logic s, input logic c, input logic e,
                       input logic u, input logic d);
        rst = r; sel = s; ce = c; se = e; ue = u; si = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] m, input logic [7:0] n,
                            input logic e);
        exp_t x;
        x.tag = tag; x.ms = m; x.cnt = n; x.err = e;
        sbq.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            vectors++;
            assert (ms === x.ms) else begin
                miscompares++;
                $error("FAIL %s mux_select got %b want %b", x.tag, ms, x.ms);
            end
            vectors++;
            assert (cnt === x.cnt) else begin
                miscompares++;
                $error("FAIL %s update_count got %0d want %0d", x.tag, cnt, x.cnt);
            end
            vectors++;
            assert (err === x.err) else begin
                miscompares++;
                $error("FAIL %s protocol_err got %b want %b", x.tag, err, x.err);
            end
        end
    endtask

    task automatic check_so(input string tag, input logic want);
        vectors++;
        assert (so === want) else begin
            miscompares++;
            $error("FAIL %s ijtag_so got %b want %b", tag, so, want);
        end
    endtask

    // Full legal capture / 4 shifts / update, shifting pat LSB first.
    task automatic csu(input logic [3:0] pat);
        cyc(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1, 0, pat[k]);
        cyc(0, 1, 0, 0, 1, 0);
    endtask

    initial begin
        int         exp_cnt;
        logic [3:0] pat;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        push_exp("reset", 4'b0000, 8'd0, 1'b0);
        check_out();
        check_so("reset_so", 1'b0);

        // Legal CSU committing 1101
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 1);
        push_exp("pre_update", 4'b0000, 8'd0, 1'b0);
        check_out();
        cyc(0, 1, 0, 0, 1, 0);
        push_exp("csu_1101", 4'b1101, 8'd1, 1'b0);
        check_out();

        // Readback of 1101 while shifting zeros in
        cyc(0, 1, 1, 0, 0, 0);
        check_so("rb0", 1'b1);
        cyc(0, 1, 0, 1, 0, 0);
        check_so("rb1", 1'b0);
        cyc(0, 1, 0, 1, 0, 0);
        check_so("rb2", 1'b1);
        cyc(0, 1, 0, 1, 0, 0);
        check_so("rb3", 1'b1);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        push_exp("csu_0000", 4'b0000, 8'd2, 1'b0);
        check_out();

        // Short shift: update suppressed and flagged
        cyc(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 1, 0);
        push_exp("short_shift", 4'b0000, 8'd2, 1'b1);
        check_out();

        // Reset clears sticky error; then ce+ue collision after a full shift
        cyc(1, 1, 0, 0, 0, 0);
        push_exp("reset2", 4'b0000, 8'd0, 1'b0);
        check_out();
        cyc(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 1, 0, 1, 0);
        push_exp("multi_en", 4'b0000, 8'd0, 1'b1);
        check_out();
        cyc(0, 1, 0, 0, 1, 0);
        push_exp("ue_after_multi", 4'b0000, 8'd0, 1'b1);
        check_out();

        // se with no capture does not arm an update
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 1, 0);
        push_exp("shift_no_capture", 4'b0000, 8'd0, 1'b1);
        check_out();

        // Reset in the middle of a shift, then a normal commit
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 1);
        cyc(1, 1, 0, 1, 0, 1);
        push_exp("mid_shift_reset", 4'b0000, 8'd0, 1'b0);
        check_out();
        check_so("mid_shift_reset_so", 1'b0);
        csu(4'b0110);
        push_exp("post_reset_csu", 4'b0110, 8'd1, 1'b0);
        check_out();

        // Saturation of update_count
        exp_cnt = 1;
        for (int i = 0; i < 260; i++) begin
            pat = 4'(i * 7 + 3);
            csu(pat);
            if (exp_cnt < 255) exp_cnt++;
            push_exp("sat_loop", pat, 8'(exp_cnt), 1'b0);
            check_out();
        end

        // sel=0 freezes everything, including a half-finished sequence
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        for (int k = 0; k < 8; k++) cyc(0, 0, k[0], k[1], k[2], ~k[0]);
        push_exp("sel0_hold", pat, 8'd255, 1'b0);
        check_out();
        check_so("sel0_so", 1'b0);
        cyc(0, 1, 0, 0, 1, 0);
        push_exp("sel0_resume", 4'b1010, 8'd255, 1'b0);
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
